cs_window_ctrl: RTL and testbench
=================================

# cs_window_ctrl

Control sequencer for the CS 9-sample sliding-window datapath. It tracks window fill level and the circular sample-buffer write pointer. It issues per-sample enables to the running-sum and approximate-value datapath, and produces the output-valid strobe aligned to the datapath's pipeline depth. It sits beside the CS datapath and owns all of its sequencing; the datapath holds only storage and arithmetic.

## Interface
- WIN, 9, window length in samples; legal range 2..15
- PIPE, 1, datapath latency in cycles from calc_en to Y valid; legal range 1..7
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- x_vld  in  1  X carries a new sample this cycle
- flush  in  1  synchronous window clear; port exists only with CS_CTRL_FLUSH_EN
- buf_we  out  1  write X into the sample buffer
- buf_waddr  out  4  buffer slot to write; this is the oldest slot once the window is full
- sum_add_en  out  1  add X to the running sum
- sum_sub_en  out  1  subtract the evicted sample (buffer[buf_waddr]) from the running sum
- calc_en  out  1  window complete including X; datapath starts a result
- y_vld  out  1  Y holds a valid result
- fill_cnt  out  4  number of valid samples in the window (0..WIN)
- state  out  2  EMPTY=0, FILL=1, FULL=2

## Operation
- Internal registers: state, wr_ptr (0..WIN-1), fill_cnt, and a PIPE-bit valid shift register.
- Combinational outputs, gated by x_vld (and by !flush when the macro is compiled in):
  - buf_we = sum_add_en = x_vld
  - buf_waddr = wr_ptr
  - sum_sub_en = x_vld & (state==FULL)
  - calc_en = x_vld & ((state==FULL) | (state==FILL & fill_cnt==WIN-1))
- On each accepted sample:
  - wr_ptr advances to wr_ptr+1, wrapping from WIN-1 to 0.
  - fill_cnt increments, saturating at WIN.
- FSM transitions:
  - EMPTY -> FILL on x_vld.
  - FILL -> FULL on x_vld when fill_cnt==WIN-1.
  - FULL stays in FULL.
  - Without x_vld, no state, pointer or count changes.
- y_vld is bit PIPE-1 of the shift register. calc_en shifts in at bit 0 every cycle, regardless of x_vld.
- Gaps in x_vld are legal. The window continues from the same pointer, and Y results track accepted samples only.
- Reset, including mid-operation: state=EMPTY, wr_ptr=0, fill_cnt=0, shift register cleared. Every output is 0 while reset is high; state and buf_waddr read 0.
- The datapath must ignore buffer contents at slots where fill_cnt shows no valid sample; the controller never reads them before FULL.

## Timing
- Sample k accepted in cycle t (x_vld=1) is written at the rising edge ending cycle t.
- With continuous x_vld starting at cycle 0, first calc_en in cycle WIN-1 (cycle 8 for WIN=9), then every cycle.
- y_vld rises in cycle WIN-1+PIPE. For defaults this is cycle 9, i.e. one result per sample thereafter.
- sum_sub_en first asserts in cycle WIN, together with the first overwrite at slot 0.
- Asynchronous reset clears registers immediately. The first sample after reset deasserts is written to slot 0.
- No combinational path from x_vld to y_vld.

## Configuration
- CS_CTRL_FLUSH_EN defined:
  - flush port present.
  - flush=1 forces EMPTY, wr_ptr=0, fill_cnt=0, and clears the shift register at the next edge.
  - All enables (buf_we, sum_add_en, sum_sub_en, calc_en) are forced 0 in the flush cycle.
  - flush together with x_vld: flush wins and the sample is dropped.
  - Results already in the pipeline are discarded, so y_vld=0 from the next cycle.
- CS_CTRL_FLUSH_EN undefined:
  - No flush port; only reset clears the window.
  - Pipeline drains normally.

## Test plan
- Reset then 20 continuous x_vld (defaults):
  - buf_waddr sequence 0..8,0..8,0,1.
  - calc_en first in cycle 8.
  - sum_sub_en first in cycle 9.
  - y_vld high from cycle 9 through cycle 20.
- x_vld pattern 1,0,1,0,... for 18 cycles:
  - fill_cnt reaches 9 on the 9th accepted sample (cycle 16).
  - calc_en in cycle 16 only.
  - Pointer holds during gaps.
- Assert reset asynchronously mid-cycle while FULL with wr_ptr=5:
  - All outputs 0 immediately.
  - After release, the first sample is written to slot 0 with state FILL.
- PIPE=3, WIN=4, continuous input: calc_en first in cycle 3, y_vld first in cycle 6.
- CS_CTRL_FLUSH_EN, flush with x_vld in cycle 12 while FULL:
  - buf_we=0 in cycle 12.
  - state=EMPTY in cycle 13.
  - y_vld=0 from cycle 13 until 9 new samples plus PIPE cycles.
- Saturation check: 100 continuous samples; fill_cnt never exceeds 9 and state stays FULL.

Source files
------------

// File: rtl/cs_window_ctrl_if.sv
// ============================================================================
//  Module  : cs_window_ctrl_if
//  Brief   : Sample/enable bundle between the CS datapath and its sequencer.
//            The flush signal exists only when CS_CTRL_FLUSH_EN is defined.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface cs_window_ctrl_if;
  logic       x_vld;
`ifdef CS_CTRL_FLUSH_EN
  logic       flush;
`endif
  logic       buf_we;
  logic [3:0] buf_waddr;
  logic       sum_add_en;
  logic       sum_sub_en;
  logic       calc_en;
  logic       y_vld;
  logic [3:0] fill_cnt;
  logic [1:0] state;

`ifdef CS_CTRL_FLUSH_EN
  modport master (
    output x_vld, flush,
    input  buf_we, buf_waddr, sum_add_en, sum_sub_en, calc_en, y_vld,
           fill_cnt, state
  );
  modport slave (
    input  x_vld, flush,
    output buf_we, buf_waddr, sum_add_en, sum_sub_en, calc_en, y_vld,
           fill_cnt, state
  );
`else
  modport master (
    output x_vld,
    input  buf_we, buf_waddr, sum_add_en, sum_sub_en, calc_en, y_vld,
           fill_cnt, state
  );
  modport slave (
    input  x_vld,
    output buf_we, buf_waddr, sum_add_en, sum_sub_en, calc_en, y_vld,
           fill_cnt, state
  );
`endif
endinterface

`default_nettype wire

// File: rtl/cs_window_ctrl.sv
// ============================================================================
//  Module  : cs_window_ctrl
//  Brief   : Sliding-window sequencer: write pointer, fill level, sum enables
//            and pipeline-aligned result strobe. Optional CS_CTRL_FLUSH_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cs_window_ctrl #(
  parameter int WIN  = 9,
  parameter int PIPE = 1
) (
  input  logic             clk,
  input  logic             reset,
  cs_window_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [3:0] C_WIN  = 4'(WIN);
  localparam logic [3:0] C_LAST = 4'(WIN - 1);

  state_t            state_q,    state_d;
  logic [3:0]        wr_ptr_q,   wr_ptr_d;
  logic [3:0]        fill_cnt_q, fill_cnt_d;
  logic [PIPE-1:0]   vld_sr_q,   vld_sr_d;

  logic              clr;
  logic              accept;
  logic              calc;

`ifdef CS_CTRL_FLUSH_EN
  assign clr = bus.flush;
`else
  assign clr = 1'b0;
`endif

  // Reset gates the enables so every output reads 0 while reset is held.
  assign accept = bus.x_vld & ~clr & ~reset;
  assign calc   = accept & ((state_q == ST_FULL) |
                            ((state_q == ST_FILL) & (fill_cnt_q == C_LAST)));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    vld_sr_d   = vld_sr_q;
    vld_sr_d[0] = calc;
    for (int i = 1; i < PIPE; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end

    if (clr) begin
      state_d    = ST_EMPTY;
      wr_ptr_d   = 4'd0;
      fill_cnt_d = 4'd0;
      vld_sr_d   = '0;
    end else if (accept) begin
      wr_ptr_d = (wr_ptr_q == C_LAST) ? 4'd0 : wr_ptr_q + 4'd1;
      if (fill_cnt_q != C_WIN) begin
        fill_cnt_d = fill_cnt_q + 4'd1;
      end
      case (state_q)
        ST_EMPTY: state_d = ST_FILL;
        ST_FILL:  if (fill_cnt_q == C_LAST) state_d = ST_FULL;
        ST_FULL:  state_d = ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= 4'd0;
      fill_cnt_q <= 4'd0;
      vld_sr_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      vld_sr_q   <= vld_sr_d;
    end
  end

  assign bus.buf_we     = accept;
  assign bus.sum_add_en = accept;
  assign bus.buf_waddr  = wr_ptr_q;
  assign bus.sum_sub_en = accept & (state_q == ST_FULL);
  assign bus.calc_en    = calc;
  assign bus.y_vld      = vld_sr_q[PIPE-1];
  assign bus.fill_cnt   = fill_cnt_q;
  assign bus.state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cs_window_ctrl.sv
// ============================================================================
//  Module  : tb_cs_window_ctrl
//  Brief   : Scoreboard bench for cs_window_ctrl, two parameter sets in parallel.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cs_window_ctrl;

  typedef struct packed {
    int         cyc;
    logic       we;
    logic [3:0] waddr;
    logic       add;
    logic       sub;
    logic       calc;
    logic       y;
    logic [3:0] fill;
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cs_window_ctrl_if if_a ();
  cs_window_ctrl_if if_b ();

  cs_window_ctrl #(.WIN(9), .PIPE(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  cs_window_ctrl #(.WIN(4), .PIPE(3)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference: accepted-sample count since the last clear, plus a log of the
  // cycles in which a result was started.
  int   n_acc[2]   = '{0, 0};
  int   epoch[2]   = '{0, 0};
  int   win_p[2]   = '{9, 4};
  int   pipe_p[2]  = '{1, 3};
  bit   calc_at[2][0:2047];

  task automatic model(input int d, input bit x, input bit r, input bit f,
                       output exp_t e);
    bit acc;
    int w;
    int p;
    w   = win_p[d];
    p   = pipe_p[d];
    acc = x && !r && !f;
    e.cyc   = cyc;
    e.we    = acc;
    e.add   = acc;
    e.waddr = r ? 4'd0 : 4'(n_acc[d] % w);
    e.fill  = r ? 4'd0 : 4'((n_acc[d] < w) ? n_acc[d] : w);
    e.st    = r ? 2'd0 : ((n_acc[d] == 0) ? 2'd0 : ((n_acc[d] < w) ? 2'd1 : 2'd2));
    e.sub   = acc && (n_acc[d] >= w);
    e.calc  = acc && (n_acc[d] >= w - 1);
    calc_at[d][cyc] = e.calc;
    if (!r && (cyc - p >= epoch[d])) e.y = calc_at[d][cyc - p];
    else                             e.y = 1'b0;
    if (r || f) begin
      n_acc[d] = 0;
      epoch[d] = cyc + 1;
    end else if (acc) begin
      n_acc[d] = n_acc[d] + 1;
    end
  endtask

  task automatic step(input bit x, input bit r, input bit f);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = r;
    if_a.x_vld = x;
    if_b.x_vld = x;
`ifdef CS_CTRL_FLUSH_EN
    if_a.flush = f;
    if_b.flush = f;
`endif
    model(0, x, r, f, e);
    q_a.push_back(e);
    model(1, x, r, f, e);
    q_b.push_back(e);
    cyc++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      g = {e.cyc, if_a.buf_we, if_a.buf_waddr, if_a.sum_add_en, if_a.sum_sub_en,
           if_a.calc_en, if_a.y_vld, if_a.fill_cnt, if_a.state};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL win9_pipe1 cyc=%0d got we=%b wa=%0d add=%b sub=%b calc=%b y=%b fill=%0d st=%0d exp we=%b wa=%0d add=%b sub=%b calc=%b y=%b fill=%0d st=%0d",
                 e.cyc, g.we, g.waddr, g.add, g.sub, g.calc, g.y, g.fill, g.st,
                 e.we, e.waddr, e.add, e.sub, e.calc, e.y, e.fill, e.st);
      end
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      g = {e.cyc, if_b.buf_we, if_b.buf_waddr, if_b.sum_add_en, if_b.sum_sub_en,
           if_b.calc_en, if_b.y_vld, if_b.fill_cnt, if_b.state};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL win4_pipe3 cyc=%0d got we=%b wa=%0d add=%b sub=%b calc=%b y=%b fill=%0d st=%0d exp we=%b wa=%0d add=%b sub=%b calc=%b y=%b fill=%0d st=%0d",
                 e.cyc, g.we, g.waddr, g.add, g.sub, g.calc, g.y, g.fill, g.st,
                 e.we, e.waddr, e.add, e.sub, e.calc, e.y, e.fill, e.st);
      end
    end
  end

  initial begin
    if_a.x_vld = 1'b0;
    if_b.x_vld = 1'b0;
`ifdef CS_CTRL_FLUSH_EN
    if_a.flush = 1'b0;
    if_b.flush = 1'b0;
`endif
    // reset state
    step(0, 1, 0);
    step(0, 1, 0);
    // continuous stream: fill, first result, wrap-around
    repeat (20) step(1, 0, 0);
    // alternating gaps: pointer must hold on idle cycles
    step(0, 1, 0);
    for (int i = 0; i < 18; i++) step((i % 2) == 0, 0, 0);
    // reset while full at wr_ptr=5, with x_vld high during reset
    step(0, 1, 0);
    repeat (14) step(1, 0, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    repeat (3) step(1, 0, 0);
`ifdef CS_CTRL_FLUSH_EN
    // flush together with a sample while full
    step(0, 1, 0);
    repeat (12) step(1, 0, 0);
    step(1, 0, 1);
    repeat (15) step(1, 0, 0);
`endif
    // long run: saturation of fill count
    step(0, 1, 0);
    repeat (100) step(1, 0, 0);
    repeat (5) step(0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", q_a.size() + q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
